// File: rtl/mr_pkg.sv
// Shared definitions for the Miller-Rabin prime search controller and its tester interface.
package mr_pkg;

   localparam int NUM_WIT = 12;
   localparam int WIT_W   = 6;
   localparam int WIDX_W  = 4;

   // Deterministic witness set; entry 0 sits in the least significant slice.
   localparam logic [NUM_WIT*WIT_W-1:0] WITNESS_ROM = {
      6'd37, 6'd31, 6'd29, 6'd23, 6'd19, 6'd17,
      6'd13, 6'd11, 6'd7,  6'd5,  6'd3,  6'd2
   };

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALIGN,
      S_SMALL,
      S_ISSUE,
      S_WAIT,
      S_NEXT,
      S_RESP
   } state_t;

endpackage

// File: rtl/mr_witness_rom.sv
// Combinational witness lookup plus a small-prime membership test for candidates up to 37.
module mr_witness_rom
   import mr_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [WIDX_W-1:0] idx,
   input  logic [W-1:0]      cand,
   output logic [WIT_W-1:0]  witness,
   output logic              is_small_prime
);

   always_comb begin
      witness        = '0;
      is_small_prime = 1'b0;
      for (int i = 0; i < NUM_WIT; i++) begin
         if (idx == WIDX_W'(i))
            witness = WITNESS_ROM[i*WIT_W +: WIT_W];
         // Every prime <= 37 is itself a witness, so set membership is the test.
         if (cand == W'(WITNESS_ROM[i*WIT_W +: WIT_W]))
            is_small_prime = 1'b1;
      end
   end

endmodule

// File: rtl/mr_prime_search.sv
// Walks odd candidates upward from a start value and runs each through a Miller-Rabin
// tester with the deterministic witness set, returning the first prime found.
module mr_prime_search
   import mr_pkg::*;
#(
   parameter int W     = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [W-1:0]     req_start,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [W-1:0]     rsp_prime,
   output logic [CNT_W-1:0] rsp_count,
   output logic             rsp_ovf,
   output logic             mr_start,
   output logic [W-1:0]     mr_n,
   output logic [WIT_W-1:0] mr_a,
   input  logic             mr_done,
   input  logic             mr_pass
);

   localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(NUM_WIT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   state_t            state, state_nx;
   logic [W-1:0]      cand;
   logic [CNT_W-1:0]  count;
   logic [WIDX_W-1:0] widx;
   logic [W-1:0]      prime_q;
   logic              ovf_q;
   logic [W:0]        cand_inc1, cand_inc2;
   logic [WIT_W-1:0]  witness;
   logic              small_prime;
   logic              is_small;

   // The extra top bit is the carry that flags a walk past 2^W-1.
   assign cand_inc1 = {1'b0, cand} + (W+1)'(1);
   assign cand_inc2 = {1'b0, cand} + (W+1)'(2);
   assign is_small  = (cand <= W'(37));

   mr_witness_rom #(.W(W)) u_rom (
      .idx            (widx),
      .cand           (cand),
      .witness        (witness),
      .is_small_prime (small_prime)
   );

   assign req_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_RESP);
   assign rsp_prime = prime_q;
   assign rsp_count = count;
   assign rsp_ovf   = ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (req_valid) state_nx = S_ALIGN;
         S_ALIGN: begin
            if (cand <= W'(2))  state_nx = S_RESP;
            else if (!cand[0])  state_nx = cand_inc1[W] ? S_RESP : S_SMALL;
            else                state_nx = S_SMALL;
         end
         S_SMALL: begin
            if (is_small) state_nx = small_prime ? S_RESP : S_NEXT;
            else          state_nx = S_ISSUE;
         end
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT: begin
            if (mr_done) begin
               if (!mr_pass)                state_nx = S_NEXT;
               else if (widx == LAST_WIDX)  state_nx = S_RESP;
               else                         state_nx = S_ISSUE;
            end
         end
         S_NEXT:  state_nx = cand_inc2[W] ? S_RESP : S_SMALL;
         S_RESP:  if (rsp_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand     <= '0;
         count    <= '0;
         widx     <= '0;
         prime_q  <= '0;
         ovf_q    <= 1'b0;
         mr_start <= 1'b0;
         mr_n     <= '0;
         mr_a     <= '0;
      end else begin
         mr_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  cand    <= req_start;
                  count   <= '0;
                  prime_q <= '0;
                  ovf_q   <= 1'b0;
               end
            end
            S_ALIGN: begin
               if (cand <= W'(2)) begin
                  cand    <= W'(2);
                  count   <= CNT_W'(1);
                  prime_q <= W'(2);
               end else if (!cand[0]) begin
                  cand <= cand_inc1[W-1:0];
                  if (cand_inc1[W]) ovf_q <= 1'b1;
               end
            end
            S_SMALL: begin
               if (count != CNT_MAX) count <= count + 1'b1;
               widx <= '0;
               if (is_small && small_prime) prime_q <= cand;
            end
            S_ISSUE: begin
               mr_n     <= cand;
               mr_a     <= witness;
               mr_start <= 1'b1;
            end
            S_WAIT: begin
               if (mr_done && mr_pass) begin
                  if (widx == LAST_WIDX) prime_q <= cand;
                  else                   widx    <= widx + 1'b1;
               end
            end
            S_NEXT: begin
               cand <= cand_inc2[W-1:0];
               if (cand_inc2[W]) begin
                  ovf_q   <= 1'b1;
                  prime_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
